// File: rtl/frame_sync_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sync_ctrl
//
// Frame-alignment controller. Hunts for a programmable serial sync pattern,
// confirms it over CONFIRM_N frame periods, then tracks lock with a flywheel
// that tolerates up to LOSS_N-1 consecutive missed checkpoints.
//
// Parameters:
//   PAT_W      sync pattern width in bits (2..16)
//   PAT_RST    pattern value loaded at reset
//   FRAME_LEN  bits per frame, >= PAT_W (4..256)
//   CONFIRM_N  consecutive on-time matches (first included) to lock (2..7)
//   LOSS_N     consecutive missed checkpoints that drop lock (1..7)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   en           in   qualifies data; one serial bit per en cycle
//   data         in   serial bit, oldest first
//   cfg_we       in   pattern load strobe (wins over en in the same cycle)
//   cfg_pattern  in   new pattern, MSB = first bit on the line
//   locked       out  high in LOCKED and FLYWHEEL
//   frame_start  out  one-cycle pulse on a confirmed on-time pattern
//   sync_err     out  one-cycle pulse on a missed checkpoint while locked
//   bit_pos      out  bit position since last pattern end (0 = just ended)
//   state        out  HUNT=0, CONFIRM=1, LOCKED=2, FLYWHEEL=3
//   loss_cnt     out  lock-loss counter, only when FRAME_SYNC_STATS_EN is
//                     defined (saturates at 16'hFFFF, cleared by cfg_we)
//
// Optional feature macro: FRAME_SYNC_STATS_EN
// -----------------------------------------------------------------------------
module frame_sync_ctrl #(
  parameter int unsigned       PAT_W     = 5,
  parameter logic [PAT_W-1:0]  PAT_RST   = 5'b10110,
  parameter int unsigned       FRAME_LEN = 16,
  parameter int unsigned       CONFIRM_N = 2,
  parameter int unsigned       LOSS_N    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         data,
  input  logic                         cfg_we,
  input  logic [PAT_W-1:0]             cfg_pattern,
  output logic                         locked,
  output logic                         frame_start,
  output logic                         sync_err,
  output logic [$clog2(FRAME_LEN)-1:0] bit_pos,
`ifdef FRAME_SYNC_STATS_EN
  output logic [15:0]                  loss_cnt,
`endif
  output logic [1:0]                   state
);

  localparam int unsigned POS_W  = $clog2(FRAME_LEN);
  localparam int unsigned FILL_W = $clog2(PAT_W);

  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(FRAME_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [2:0]        HIT_TGT   = 3'(CONFIRM_N);
  localparam logic [2:0]        MISS_TGT  = 3'(LOSS_N);

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_CONFIRM  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FLYWHEEL = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [PAT_W-1:0]  r_pattern;
  logic [PAT_W-2:0]  r_sr;
  logic [FILL_W-1:0] r_fill;
  logic [POS_W-1:0]  r_bit_pos;
  logic [2:0]        r_hits;
  logic [2:0]        r_misses;
  logic              r_frame_start;
  logic              r_sync_err;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic              w_frame_start_nxt;
  logic              w_sync_err_nxt;
  logic [PAT_W-1:0]  w_window;
  logic              w_match;
  logic              w_checkpoint;
  logic              w_advance;
  logic              w_hit_last;
  logic              w_miss_last;
  logic              w_in_lock;

  // The window is the candidate pattern with the incoming bit as its LSB.
  assign w_window     = {r_sr, data};
  assign w_match      = (w_window == r_pattern) && (r_fill == FILL_FULL);
  // bit_pos is pinned at 0 in HUNT, so a checkpoint only exists once aligned.
  assign w_checkpoint = (r_state != ST_HUNT) && (r_bit_pos == LAST_POS);
  // A bit is consumed only when no reconfiguration is pending this cycle.
  assign w_advance    = en && !cfg_we;
  assign w_hit_last   = (r_hits + 3'd1) == HIT_TGT;
  assign w_miss_last  = (r_misses + 3'd1) >= MISS_TGT;
  assign w_in_lock    = (r_state == ST_LOCKED) || (r_state == ST_FLYWHEEL);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: a default assignment at the top of each always_comb keeps every
  // path assigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_we) begin
      w_state_nxt = ST_HUNT;
    end else if (en) begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_match) w_state_nxt = ST_CONFIRM;
        end
        ST_CONFIRM: begin
          if (w_checkpoint) begin
            if (!w_match)       w_state_nxt = ST_HUNT;
            else if (w_hit_last) w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_checkpoint && !w_match) begin
            w_state_nxt = (LOSS_N == 1) ? ST_HUNT : ST_FLYWHEEL;
          end
        end
        ST_FLYWHEEL: begin
          if (w_checkpoint) begin
            if (w_match)          w_state_nxt = ST_LOCKED;
            else if (w_miss_last) w_state_nxt = ST_HUNT;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (pulses are registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_frame_start_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;
    if (w_advance && w_checkpoint) begin
      unique case (r_state)
        ST_CONFIRM: w_frame_start_nxt = w_match && w_hit_last;
        ST_LOCKED,
        ST_FLYWHEEL: begin
          w_frame_start_nxt = w_match;
          w_sync_err_nxt    = !w_match;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, fill counter, pattern, position, hit/miss
  // ---------------------------------------------------------------------------
  // NOTE: the pattern register is reset to PAT_RST because the detector is
  // live straight out of reset; it is a control register, not a memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern     <= PAT_RST;
      r_sr          <= '0;
      r_fill        <= '0;
      r_bit_pos     <= '0;
      r_hits        <= '0;
      r_misses      <= '0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start_nxt;
      r_sync_err    <= w_sync_err_nxt;

      if (cfg_we) begin
        r_pattern <= cfg_pattern;
        r_sr      <= '0;
        r_fill    <= '0;
        r_bit_pos <= '0;
        r_hits    <= '0;
        r_misses  <= '0;
      end else if (en) begin
        r_sr <= w_window[PAT_W-2:0];
        if (r_fill != FILL_FULL) r_fill <= r_fill + FILL_W'(1);

        // Position restarts at every checkpoint and stays at 0 while hunting;
        // a HUNT match leaves it at 0, marking the pattern end as position 0.
        if ((r_state == ST_HUNT) || w_checkpoint) r_bit_pos <= '0;
        else                                       r_bit_pos <= r_bit_pos + POS_W'(1);

        if ((r_state == ST_HUNT) && w_match) begin
          r_hits <= 3'd1;
        end else if ((r_state == ST_CONFIRM) && w_checkpoint && w_match) begin
          r_hits <= r_hits + 3'd1;
        end

        // Misses are zero on entry to LOCKED, so +1 yields 1 on the first miss.
        if (w_state_nxt == ST_HUNT) begin
          r_misses <= '0;
        end else if (w_in_lock && w_checkpoint) begin
          r_misses <= w_match ? 3'd0 : (r_misses + 3'd1);
        end
      end
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  // ---------------------------------------------------------------------------
  // Lock-loss statistics: counts falls from LOCKED/FLYWHEEL back to HUNT.
  // ---------------------------------------------------------------------------
  logic [15:0] r_loss_cnt;
  logic        w_loss_event;

  assign w_loss_event = w_advance && w_in_lock && (w_state_nxt == ST_HUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_loss_cnt <= '0;
    end else if (cfg_we) begin
      r_loss_cnt <= '0;
    end else if (w_loss_event && (r_loss_cnt != 16'hFFFF)) begin
      r_loss_cnt <= r_loss_cnt + 16'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign state       = r_state;
  assign locked      = w_in_lock;
  assign frame_start = r_frame_start;
  assign sync_err    = r_sync_err;
  assign bit_pos     = r_bit_pos;

endmodule
